// File: rtl/abs_cmd_exec_pkg.sv
// Shared types and constants for the abstract-command execution sequencer.
// cmderr codes, FSM encoding and the default ack timeout.
package abs_cmd_exec_pkg;

    localparam logic [2:0] CMDERR_NONE   = 3'd0;
    localparam logic [2:0] CMDERR_BUSY   = 3'd1;
    localparam logic [2:0] CMDERR_EXCEPT = 3'd3;
    localparam logic [2:0] CMDERR_HALT   = 3'd4;
    localparam logic [2:0] CMDERR_OTHER  = 3'd7;

    localparam int ABS_CMD_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/abs_cmd_exec.sv
// Abstract-command sequencer: one req/ack transaction on the core debug
// register port per accepted command, with data0 writeback and cmderr.
module abs_cmd_exec
    import abs_cmd_exec_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int REGNO_WIDTH = 16,
    parameter int TIMEOUT     = ABS_CMD_TIMEOUT
) (
    input  logic                   sys_clk,
    input  logic                   sys_rstn,
    input  logic                   valid_reg_access,
    input  logic                   wr1_rd0,
    input  logic [REGNO_WIDTH-1:0] regno,
    input  logic [DATA_WIDTH-1:0]  write_data,
    input  logic                   core_halted,
    input  logic                   cmderr_clr,
    output logic                   dbg_req,
    output logic                   dbg_we,
    output logic [REGNO_WIDTH-1:0] dbg_regno,
    output logic [DATA_WIDTH-1:0]  dbg_wdata,
    input  logic                   dbg_ack,
    input  logic                   dbg_err,
    input  logic [DATA_WIDTH-1:0]  dbg_rdata,
    output logic                   data0_wr,
    output logic [DATA_WIDTH-1:0]  data0_wdata,
    output logic                   busy,
    output logic [2:0]             cmderr
);

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_t     state;
    logic [7:0] cnt;
    logic       err_q;
    logic       tmo_q;

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            err_q       <= 1'b0;
            tmo_q       <= 1'b0;
            dbg_req     <= 1'b0;
            dbg_we      <= 1'b0;
            dbg_regno   <= '0;
            dbg_wdata   <= '0;
            data0_wr    <= 1'b0;
            data0_wdata <= '0;
            busy        <= 1'b0;
            cmderr      <= CMDERR_NONE;
        end else begin
            data0_wr <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (valid_reg_access && cmderr == CMDERR_NONE
                        && core_halted) begin
                        state     <= ST_REQ;
                        cnt       <= '0;
                        err_q     <= 1'b0;
                        tmo_q     <= 1'b0;
                        dbg_req   <= 1'b1;
                        dbg_we    <= wr1_rd0;
                        dbg_regno <= regno;
                        dbg_wdata <= write_data;
                        busy      <= 1'b1;
                    end
                end
                ST_REQ: begin
                    // Ack beats a timeout expiring in the same cycle.
                    if (dbg_ack) begin
                        state       <= ST_DONE;
                        dbg_req     <= 1'b0;
                        dbg_we      <= 1'b0;
                        err_q       <= dbg_err;
                        data0_wr    <= !dbg_we && !dbg_err;
                        data0_wdata <= dbg_rdata;
                    end else if (cnt == TMO) begin
                        state   <= ST_DONE;
                        dbg_req <= 1'b0;
                        dbg_we  <= 1'b0;
                        tmo_q   <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // Sticky: only a clear may take cmderr away from non-zero.
            if (cmderr_clr) begin
                cmderr <= CMDERR_NONE;
            end else if (cmderr == CMDERR_NONE) begin
                if (state == ST_DONE && err_q)
                    cmderr <= CMDERR_EXCEPT;
                else if (state == ST_DONE && tmo_q)
                    cmderr <= CMDERR_OTHER;
                else if (valid_reg_access && state != ST_IDLE)
                    cmderr <= CMDERR_BUSY;
                else if (valid_reg_access && !core_halted)
                    cmderr <= CMDERR_HALT;
            end
        end
    end

endmodule

// File: tb/tb_abs_cmd_exec.sv
// Directed bench for abs_cmd_exec with TIMEOUT=4.
// Each step is checked by an immediate assertion.
module tb_abs_cmd_exec;

    logic        clk;
    logic        rstn;
    logic        valid;
    logic        wr;
    logic [15:0] regno;
    logic [31:0] wdata;
    logic        halted;
    logic        clr;
    logic        req;
    logic        we;
    logic [15:0] dregno;
    logic [31:0] dwdata;
    logic        ack;
    logic        err;
    logic [31:0] rdata;
    logic        d0wr;
    logic [31:0] d0data;
    logic        busy;
    logic [2:0]  cmderr;

    int vectors;
    int miscompares;
    int busy_cycles;
    int req_cycles;
    int wr_pulses;

    abs_cmd_exec #(
        .DATA_WIDTH (32),
        .REGNO_WIDTH(16),
        .TIMEOUT    (4)
    ) dut (
        .sys_clk         (clk),
        .sys_rstn        (rstn),
        .valid_reg_access(valid),
        .wr1_rd0         (wr),
        .regno           (regno),
        .write_data      (wdata),
        .core_halted     (halted),
        .cmderr_clr      (clr),
        .dbg_req         (req),
        .dbg_we          (we),
        .dbg_regno       (dregno),
        .dbg_wdata       (dwdata),
        .dbg_ack         (ack),
        .dbg_err         (err),
        .dbg_rdata       (rdata),
        .data0_wr        (d0wr),
        .data0_wdata     (d0data),
        .busy            (busy),
        .cmderr          (cmderr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (busy) busy_cycles++;
        if (req) req_cycles++;
        if (d0wr) wr_pulses++;
    endtask

    task automatic clr_counts();
        busy_cycles = 0;
        req_cycles  = 0;
        wr_pulses   = 0;
    endtask

    task automatic issue(input logic w, input logic [15:0] r,
                         input logic [31:0] d);
        valid = 1'b1;
        wr    = w;
        regno = r;
        wdata = d;
        tick();
        valid = 1'b0;
    endtask

    task automatic clear_err();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        clr_counts();
        rstn = 1'b0;
        valid = 1'b0;
        wr = 1'b0;
        regno = '0;
        wdata = '0;
        halted = 1'b1;
        clr = 1'b0;
        ack = 1'b0;
        err = 1'b0;
        rdata = '0;

        #12;
        chk("rst_req", 32'(req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cmderr", 32'(cmderr), 0);
        chk("rst_regno", 32'(dregno), 0);
        chk("rst_d0data", d0data, 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        tick();

        // read 0x1001, ack after 3 waiting cycles
        clr_counts();
        issue(1'b0, 16'h1001, 32'h0);
        chk("rd_req", 32'(req), 1);
        chk("rd_we", 32'(we), 0);
        chk("rd_regno", 32'(dregno), 32'h1001);
        tick();
        tick();
        tick();
        ack = 1'b1;
        rdata = 32'hDEADBEEF;
        tick();
        ack = 1'b0;
        chk("rd_d0wr", 32'(d0wr), 1);
        chk("rd_d0data", d0data, 32'hDEADBEEF);
        tick();
        chk("rd_busy_cycles", busy_cycles, 5);
        chk("rd_wr_pulses", wr_pulses, 1);
        chk("rd_cmderr", 32'(cmderr), 0);

        // write 0x0300, ack in first REQ cycle
        clr_counts();
        issue(1'b1, 16'h0300, 32'h12345678);
        chk("wr_we", 32'(we), 1);
        chk("wr_wdata", dwdata, 32'h12345678);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        chk("wr_busy_cycles", busy_cycles, 2);
        chk("wr_wr_pulses", wr_pulses, 0);

        // not halted
        clr_counts();
        halted = 1'b0;
        issue(1'b0, 16'h1000, 32'h0);
        chk("halt_cmderr", 32'(cmderr), 4);
        chk("halt_req", 32'(req), 0);
        halted = 1'b1;
        issue(1'b0, 16'h1000, 32'h0);
        chk("halt_ignored_busy", 32'(busy), 0);
        chk("halt_sticky", 32'(cmderr), 4);
        clear_err();
        chk("halt_clr", 32'(cmderr), 0);
        chk("halt_req_total", req_cycles, 0);

        // second command while in REQ
        issue(1'b1, 16'h0055, 32'hCAFE0001);
        issue(1'b0, 16'h0777, 32'h0000AAAA);
        chk("busy_cmderr", 32'(cmderr), 1);
        chk("busy_regno", 32'(dregno), 32'h0055);
        chk("busy_wdata", dwdata, 32'hCAFE0001);
        chk("busy_req", 32'(req), 1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        chk("busy_done", 32'(busy), 0);
        chk("busy_sticky", 32'(cmderr), 1);
        clear_err();

        // read with error
        clr_counts();
        issue(1'b0, 16'h2000, 32'h0);
        ack = 1'b1;
        err = 1'b1;
        rdata = 32'h55555555;
        tick();
        ack = 1'b0;
        err = 1'b0;
        chk("err_d0wr", 32'(d0wr), 0);
        tick();
        chk("err_cmderr", 32'(cmderr), 3);
        chk("err_wr_pulses", wr_pulses, 0);
        clear_err();

        // ack in the cycle the counter reaches TIMEOUT
        clr_counts();
        issue(1'b0, 16'h0010, 32'h0);
        repeat (4) tick();
        ack = 1'b1;
        rdata = 32'h0BADF00D;
        tick();
        ack = 1'b0;
        chk("edge_d0wr", 32'(d0wr), 1);
        chk("edge_d0data", d0data, 32'h0BADF00D);
        tick();
        chk("edge_cmderr", 32'(cmderr), 0);
        chk("edge_req_cycles", req_cycles, 5);

        // timeout
        clr_counts();
        issue(1'b0, 16'h0020, 32'h0);
        for (int g = 0; g < 20 && busy; g++) tick();
        chk("tmo_busy_fell", 32'(busy), 0);
        chk("tmo_req_cycles", req_cycles, 5);
        chk("tmo_cmderr", 32'(cmderr), 7);
        chk("tmo_wr_pulses", wr_pulses, 0);
        clear_err();

        // reset while in REQ
        issue(1'b1, 16'h0abc, 32'hFEEDFACE);
        chk("rr_req", 32'(req), 1);
        #1;
        rstn = 1'b0;
        #1;
        chk("rr_req0", 32'(req), 0);
        chk("rr_we0", 32'(we), 0);
        chk("rr_busy0", 32'(busy), 0);
        chk("rr_regno0", 32'(dregno), 0);
        chk("rr_wdata0", dwdata, 0);
        chk("rr_d0data0", d0data, 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        ack = 1'b1;
        rdata = 32'h77777777;
        tick();
        ack = 1'b0;
        chk("rr_ack_ignored_wr", 32'(d0wr), 0);
        chk("rr_ack_ignored_busy", 32'(busy), 0);
        chk("rr_cmderr", 32'(cmderr), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
